// File: rtl/uncache_mem_slave_pkg.sv
// Shared defines for the uncached memory slave: RV opcodes, access sizes,
// FSM states and byte-lane helpers.
package uncache_mem_slave_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [7:0] byte_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/uncache_mem_slave_if.sv
// Request/response bus between an uncached-access initiator and the memory slave.
interface uncache_mem_slave_if;
    logic        uncache_mem_vld_i;
    logic        uncache_mem_ready_o;
    logic        uncache_mem_write_i;
    logic [2:0]  uncache_mem_size_i;
    logic [63:0] uncache_mem_addr_i;
    logic [63:0] uncache_mem_wdata_i;
    logic        uncache_mem_resp_vld_o;
    logic        uncache_mem_resp_rdy_i;
    logic [63:0] uncache_mem_resp_data_o;
    logic        uncache_mem_err_o;

    modport master (
        output uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i,
               uncache_mem_addr_i, uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
        input  uncache_mem_ready_o, uncache_mem_resp_vld_o,
               uncache_mem_resp_data_o, uncache_mem_err_o
    );

    modport slave (
        input  uncache_mem_vld_i, uncache_mem_write_i, uncache_mem_size_i,
               uncache_mem_addr_i, uncache_mem_wdata_i, uncache_mem_resp_rdy_i,
        output uncache_mem_ready_o, uncache_mem_resp_vld_o,
               uncache_mem_resp_data_o, uncache_mem_err_o
    );
endinterface

// File: rtl/uncache_mem_ram.sv
// 64-bit word RAM with byte strobes derived from size/offset; synchronous
// write, combinational read. Contents are not reset.
module uncache_mem_ram
    import uncache_mem_slave_pkg::*;
#(
    parameter int RAM_WORDS = 512,
    parameter int AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [2:0]    off,
    input  logic [1:0]    size,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [63:0] mem [RAM_WORDS];
    logic [7:0]  strb;
    logic [63:0] wdata_sh;

    assign strb     = byte_mask(size) << off;
    assign wdata_sh = wdata << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/uncache_mem_slave.sv
// Uncached memory slave: stores commit on accept, loads respond after a
// fixed latency and wait for the initiator's resp_rdy handshake.
module uncache_mem_slave
    import uncache_mem_slave_pkg::*;
#(
    parameter int          RAM_WORDS = 512,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input logic                clk,
    input logic                rst_n,
    uncache_mem_slave_if.slave bus
);
    localparam int          AW   = $clog2(RAM_WORDS);
    localparam logic [63:0] SPAN = 64'(RAM_WORDS) << 3;

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        resp_vld_q;
    logic        err_q;
    logic [63:0] resp_data_q;
    logic [63:0] pend_data;
    logic        pend_err;

    logic [63:0] rel;
    logic [63:0] ram_word;
    logic [63:0] load_data;
    logic        req_err;
    logic        accept;
    logic        ram_we;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
    assign rel     = bus.uncache_mem_addr_i - BASE_ADDR;
    assign req_err = bus.uncache_mem_size_i[2]
                   | misaligned(bus.uncache_mem_size_i[1:0], bus.uncache_mem_addr_i[2:0])
                   | (rel >= SPAN);
    assign accept  = bus.uncache_mem_vld_i & ready_q;
    assign ram_we  = accept & bus.uncache_mem_write_i & ~req_err;

    assign load_data = (ram_word >> {bus.uncache_mem_addr_i[2:0], 3'b000})
                     & size_mask(bus.uncache_mem_size_i[1:0]);

    uncache_mem_ram #(
        .RAM_WORDS (RAM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (rel[3 +: AW]),
        .off   (bus.uncache_mem_addr_i[2:0]),
        .size  (bus.uncache_mem_size_i[1:0]),
        .wdata (bus.uncache_mem_wdata_i),
        .rdata (ram_word)
    );

    // Load data is captured at accept; no store can land before the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b1;
            resp_vld_q  <= 1'b0;
            resp_data_q <= 64'd0;
            err_q       <= 1'b0;
            pend_data   <= 64'd0;
            pend_err    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.uncache_mem_write_i) begin
                            err_q <= req_err;
                        end else begin
                            pend_data <= req_err ? 64'd0 : load_data;
                            pend_err  <= req_err;
                            cnt       <= 4'(LATENCY - 1);
                            ready_q   <= 1'b0;
                            state     <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                // First RESP cycle raises the response; later cycles hold it until taken.
                ST_RESP: begin
                    if (!resp_vld_q) begin
                        resp_vld_q  <= 1'b1;
                        resp_data_q <= pend_data;
                        err_q       <= pend_err;
                    end else if (bus.uncache_mem_resp_rdy_i) begin
                        resp_vld_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uncache_mem_ready_o     = ready_q;
    assign bus.uncache_mem_resp_vld_o  = resp_vld_q;
    assign bus.uncache_mem_resp_data_o = resp_data_q;
    assign bus.uncache_mem_err_o       = err_q;

endmodule

// File: tb/tb_uncache_mem_slave.sv
// Scoreboard bench for uncache_mem_slave: stimulus pushes expected responses
// and error pulses, a negedge monitor pops and compares them.
module tb_uncache_mem_slave;
    import uncache_mem_slave_pkg::*;

    localparam int          RAM_WORDS = 512;
    localparam int          LATENCY   = 2;
    localparam logic [63:0] B         = 64'h0000_0000_8000_0000;

    typedef struct {
        logic        is_load;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rise_cyc = 0;
    exp_t sb[$];
    exp_t cur;

    uncache_mem_slave_if bus ();

    uncache_mem_slave #(
        .RAM_WORDS (RAM_WORDS),
        .LATENCY   (LATENCY),
        .BASE_ADDR (B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: act=0x%0h req=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: response popped when resp_vld rises, store errors when err pulses alone.
    initial begin
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.uncache_mem_resp_vld_o && !prev_vld) begin
                checkOutput("sb nonempty at resp", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    rise_cyc = cyc;
                    checkOutput("resp is load", 64'(cur.is_load), 64'd1);
                    checkOutput("resp data", bus.uncache_mem_resp_data_o, cur.data);
                    checkOutput("resp err", 64'(bus.uncache_mem_err_o), 64'(cur.err));
                end
            end else if (bus.uncache_mem_resp_vld_o) begin
                checkOutput("resp hold data", bus.uncache_mem_resp_data_o, cur.data);
                checkOutput("resp hold err", 64'(bus.uncache_mem_err_o), 64'd0);
            end else if (bus.uncache_mem_err_o) begin
                checkOutput("sb nonempty at store err", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    checkOutput("store err expected", 64'(cur.is_load), 64'd0);
                end
            end
            prev_vld = bus.uncache_mem_resp_vld_o;
        end
    end

    // Presents one request, waits for ready, returns the cycle of the accept edge.
    task automatic applyStimulus(input logic wr, input logic [2:0] sz, input logic [63:0] addr,
                                 input logic [63:0] wd, output int acc);
        bus.uncache_mem_vld_i   = 1'b1;
        bus.uncache_mem_write_i = wr;
        bus.uncache_mem_size_i  = sz;
        bus.uncache_mem_addr_i  = addr;
        bus.uncache_mem_wdata_i = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.uncache_mem_ready_o) break;
        end
        checkOutput("ready before accept", 64'(bus.uncache_mem_ready_o), 64'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.uncache_mem_vld_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.uncache_mem_ready_o && !bus.uncache_mem_resp_vld_o) break;
        end
        checkOutput("back to idle", 64'(bus.uncache_mem_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [2:0] sz, input logic [63:0] addr,
                            input logic [63:0] wd, input logic err);
        int acc;
        if (err) sb.push_back('{is_load: 1'b0, data: 64'd0, err: 1'b1});
        applyStimulus(1'b1, sz, addr, wd, acc);
        @(negedge clk);
        checkOutput("ready after store", 64'(bus.uncache_mem_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] sz, input logic [63:0] addr,
                           input logic [63:0] data, input logic err);
        int acc;
        sb.push_back('{is_load: 1'b1, data: data, err: err});
        applyStimulus(1'b0, sz, addr, 64'd0, acc);
        wait_idle();
        checkOutput("load latency", 64'(rise_cyc - acc), 64'(LATENCY));
    endtask

    initial begin
        int acc;
        logic saw_vld;
        bus.uncache_mem_vld_i      = 1'b0;
        bus.uncache_mem_write_i    = 1'b0;
        bus.uncache_mem_size_i     = SZ_B;
        bus.uncache_mem_addr_i     = B;
        bus.uncache_mem_wdata_i    = 64'd0;
        bus.uncache_mem_resp_rdy_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset resp_vld", 64'(bus.uncache_mem_resp_vld_o), 64'd0);
        checkOutput("reset resp_data", bus.uncache_mem_resp_data_o, 64'd0);
        checkOutput("reset err", 64'(bus.uncache_mem_err_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready after reset", 64'(bus.uncache_mem_ready_o), 64'd1);

        do_store(SZ_D, B, 64'h1122_3344_5566_7788, 1'b0);
        do_load(SZ_D, B, 64'h1122_3344_5566_7788, 1'b0);

        do_store(SZ_B, B + 5, 64'h0000_0000_0000_00AB, 1'b0);
        do_load(SZ_B, B + 5, 64'h0000_0000_0000_00AB, 1'b0);
        do_load(SZ_D, B, 64'h1122_AB44_5566_7788, 1'b0);

        do_load(SZ_W, B + 2, 64'd0, 1'b1);
        do_store(SZ_H, B + 64'(RAM_WORDS * 8), 64'h0000_0000_0000_BEEF, 1'b1);
        do_load(SZ_D, B, 64'h1122_AB44_5566_7788, 1'b0);
        do_store(SZ_W, B + 2, 64'h0000_0000_1234_5678, 1'b1);
        do_load(SZ_D, B, 64'h1122_AB44_5566_7788, 1'b0);

        do_store(SZ_D, B + 8, 64'd0, 1'b0);
        do_store(SZ_W, B + 12, 64'h0000_0000_DEAD_BEEF, 1'b0);
        do_load(SZ_D, B + 8, 64'hDEAD_BEEF_0000_0000, 1'b0);
        do_load(SZ_H, B + 14, 64'h0000_0000_0000_DEAD, 1'b0);
        do_load(SZ_B, B + 12, 64'h0000_0000_0000_00EF, 1'b0);
        do_load(SZ_H, B + 10, 64'd0, 1'b0);
        do_store(SZ_B, B + 9, 64'hFFFF_FFFF_FFFF_FF5A, 1'b0);
        do_load(SZ_D, B + 8, 64'hDEAD_BEEF_0000_5A00, 1'b0);

        do_load(3'd4, B, 64'd0, 1'b1);
        do_load(SZ_D, B - 8, 64'd0, 1'b1);

        // Response held off by the initiator for five cycles.
        bus.uncache_mem_resp_rdy_i = 1'b0;
        sb.push_back('{is_load: 1'b1, data: 64'hDEAD_BEEF_0000_5A00, err: 1'b0});
        applyStimulus(1'b0, SZ_D, B + 8, 64'd0, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.uncache_mem_resp_vld_o) break;
        end
        for (int k = 0; k < 6; k++) begin
            checkOutput("stall resp_vld", 64'(bus.uncache_mem_resp_vld_o), 64'd1);
            checkOutput("stall data", bus.uncache_mem_resp_data_o, 64'hDEAD_BEEF_0000_5A00);
            checkOutput("stall ready", 64'(bus.uncache_mem_ready_o), 64'd0);
            if (k == 5) bus.uncache_mem_resp_rdy_i = 1'b1;
            else @(negedge clk);
        end
        wait_idle();
        checkOutput("stall latency", 64'(rise_cyc - acc), 64'(LATENCY));

        // Four stores then a load with vld never dropping.
        sb.push_back('{is_load: 1'b1, data: 64'h0000_0000_0403_0201, err: 1'b0});
        bus.uncache_mem_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.uncache_mem_write_i = (i < 4);
            bus.uncache_mem_size_i  = (i < 4) ? SZ_B : SZ_W;
            bus.uncache_mem_addr_i  = B + 16 + ((i < 4) ? 64'(i) : 64'd0);
            bus.uncache_mem_wdata_i = 64'(i + 1);
            @(negedge clk);
            checkOutput("b2b ready", 64'(bus.uncache_mem_ready_o), 64'd1);
            @(posedge clk);
            #1;
        end
        acc = cyc;
        bus.uncache_mem_vld_i = 1'b0;
        checkOutput("b2b load taken on 5th edge", 64'(bus.uncache_mem_ready_o), 64'd0);
        wait_idle();
        checkOutput("b2b latency", 64'(rise_cyc - acc), 64'(LATENCY));

        // Reset while the load is in WAIT must drop its response.
        applyStimulus(1'b0, SZ_D, B, 64'd0, acc);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid-wait reset resp_vld", 64'(bus.uncache_mem_resp_vld_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.uncache_mem_resp_vld_o) saw_vld = 1'b1;
        end
        checkOutput("dropped resp never valid", 64'(saw_vld), 64'd0);
        checkOutput("ready after mid-wait reset", 64'(bus.uncache_mem_ready_o), 64'd1);
        @(posedge clk);
        #1;
        do_load(SZ_D, B, 64'h1122_AB44_5566_7788, 1'b0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uncache_mem_slave.md
UNCACHE_MEM_SLAVE -- requirements
Module: uncache_mem_slave

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 512, depth of the 64-bit backing RAM, power of two.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from load accept to response valid; legal range 1..15.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, byte address of RAM word 0.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 uncache_mem_vld_i  input  1  request valid from initiator.
REQ-008 uncache_mem_ready_o  output  1  slave can accept a request this cycle.
REQ-009 uncache_mem_write_i  input  1  1 = store, 0 = load.
REQ-010 uncache_mem_size_i  input  3  access size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B; 4..7 illegal.
REQ-011 uncache_mem_addr_i  input  64  byte address.
REQ-012 uncache_mem_wdata_i  input  64  store data, right-aligned in bits [8*bytes-1:0].
REQ-013 uncache_mem_resp_vld_o  output  1  load response valid.
REQ-014 uncache_mem_resp_rdy_i  input  1  initiator accepts the response.
REQ-015 uncache_mem_resp_data_o  output  64  load data, right-aligned, zero-extended.
REQ-016 uncache_mem_err_o  output  1  one-cycle pulse flagging an errored request.

Function
REQ-017 A request SHALL be accepted on a rising edge where vld_i && ready_o.
REQ-018 States SHALL be IDLE, WAIT and RESP; ready_o SHALL be 1 only in IDLE.
REQ-019 Store accepted in IDLE: write committed on the accept edge, state stays IDLE, no response issued; back-to-back stores SHALL be accepted every cycle.
REQ-020 Load accepted in IDLE: latency counter loaded with LATENCY-1; go to RESP if LATENCY==1, otherwise to WAIT.
REQ-021 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 1, so resp_vld_o rises exactly LATENCY cycles after the accept edge.
REQ-022 RESP SHALL hold resp_vld_o and resp_data_o stable until resp_vld_o && resp_rdy_i, then return to IDLE on that edge.
REQ-023 Offset off = addr[2:0]; word index = (addr - BASE_ADDR) >> 3.
REQ-024 Store SHALL write byte lanes off..off+bytes-1 with wdata shifted left by 8*off; all other lanes unchanged.
REQ-025 Load SHALL return RAM word >> (8*off), masked to its size, upper bits zero.
REQ-026 Error conditions: size_i > 3; addr not a multiple of the size; address outside BASE_ADDR..BASE_ADDR+8*RAM_WORDS-1.
REQ-027 An errored store SHALL write nothing; err_o SHALL pulse the cycle after the accept edge.
REQ-028 An errored load SHALL follow normal latency and handshake, return data 0, and pulse err_o in the cycle resp_vld_o first rises.
REQ-029 A load accepted the cycle after a store to the same address SHALL return the stored data.
REQ-030 A request presented while in WAIT or RESP SHALL be ignored; the initiator holds it until ready_o is 1.

Reset
REQ-031 On rst_n low: state IDLE, counter 0, resp_vld_o 0, resp_data_o 0, err_o 0, ready_o 1 once rst_n is released.
REQ-032 Reset mid-WAIT or mid-RESP SHALL drop the pending response; RAM contents are not reset and are undefined after power-up.

Structure
REQ-033 Size encodings (SZ_B/H/W/D) and the state enum SHALL live in the shared defines package next to the RV opcode constants.
REQ-034 Byte-lane mask generation and the RAM array SHALL be one sub-module, uncache_mem_ram (64-bit word, 8-bit write strobe, synchronous write, combinational read).

Verification
REQ-035 Store SD 0x1122334455667788 @BASE, then LD @BASE with LATENCY=2 -> resp_vld_o rises 2 cycles after accept, data 0x1122334455667788, err_o 0.
REQ-036 Store SB 0xAB @BASE+5 onto the word above, then LBU @BASE+5 -> 0xAB; LD @BASE -> 0x1122AB4455667788.
REQ-037 LW @BASE+2 (misaligned) -> response data 0, err_o pulses once; SH @BASE+8*RAM_WORDS -> no RAM change, err_o pulses, ready_o stays 1.
REQ-038 Load response with resp_rdy_i held low 5 cycles -> resp_vld_o and data stable for 6 cycles, ready_o 0 throughout, IDLE after handshake.
REQ-039 4 back-to-back stores then a load, vld_i held high -> stores accepted on 4 consecutive edges, load on the 5th edge.
REQ-040 rst_n pulsed low during WAIT -> resp_vld_o never asserts; next load completes normally.
